// File: rtl/regfile_32x64.sv
//-----------------------------------------------------------------------------
// Module   : regfile_32x64
// Brief    : ARM64 integer register file with 31 stored registers (X0-X30)
//            and a hardwired zero register X31 (XZR). It has two
//            combinational read ports and one write port. The write enable
//            comes from a 5:32 decoder built from 2:4 and 3:8 cells, and the
//            2:4 cell is enabled by RegWrite.
// Options  : REGFILE_WRITE_BYPASS_EN - a same-cycle write is forwarded to
//            any read port that addresses the write target.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module regfile_32x64 #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [4:0]            WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [4:0]            ReadRegister1,
  input  logic [4:0]            ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  // Outputs of the decoder cells. The 2:4 cell selects a bank of eight
  // registers. The 3:8 cell selects the register inside that bank.
  logic [3:0]            w_dec_hi;
  logic [7:0]            w_dec_lo;
  // One-hot write enable. Bit 31 (XZR) is never formed, because it would
  // have no storage to drive.
  logic [30:0]           w_wen;

  // Stored registers X0-X30.
  logic [DATA_WIDTH-1:0] r_x [0:30];
  // Read view of all 32 registers. Entry 31 is tied to zero.
  logic [DATA_WIDTH-1:0] w_rf [0:31];

  // 2:4 decoder cell on WriteRegister[4:3]. RegWrite enables it, so all
  // of its outputs are zero when no write is requested.
  always_comb begin
    w_dec_hi = 4'b0000;
    if (RegWrite) begin
      w_dec_hi[WriteRegister[4:3]] = 1'b1;
    end
  end

  // 3:8 decoder cell on WriteRegister[2:0].
  always_comb begin
    w_dec_lo = 8'b0000_0000;
    w_dec_lo[WriteRegister[2:0]] = 1'b1;
  end

  // Combine the bank select and the register select into the one-hot enable.
  genvar gi;
  generate
    for (gi = 0; gi < 31; gi++) begin : g_wen
      assign w_wen[gi] = w_dec_hi[gi / 8] & w_dec_lo[gi % 8];
    end
  endgenerate

  // Register storage. Reset clears a register at once. While reset is
  // high, reset also wins over a write on a coincident clock edge.
  generate
    for (gi = 0; gi < 31; gi++) begin : g_reg
      // Xi: asynchronous clear, load WriteData when its enable is set
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_x[gi] <= '0;
        end else if (w_wen[gi]) begin
          r_x[gi] <= WriteData;
        end
      end
    end
  endgenerate

  // Build the 32-entry read view. X31 has no storage and always reads zero.
  generate
    for (gi = 0; gi < 31; gi++) begin : g_rview
      assign w_rf[gi] = r_x[gi];
    end
  endgenerate
  assign w_rf[31] = '0;

`ifdef REGFILE_WRITE_BYPASS_EN
  // Forward the write to a read port when it addresses the register being
  // written this cycle. Writes to XZR and writes during reset never forward.
  logic w_byp1;
  logic w_byp2;
  assign w_byp1 = RegWrite & ~reset & (WriteRegister != 5'd31) &
                  (WriteRegister == ReadRegister1);
  assign w_byp2 = RegWrite & ~reset & (WriteRegister != 5'd31) &
                  (WriteRegister == ReadRegister2);

  // Combinational read ports, with same-cycle write-through forwarding
  always_comb begin
    ReadData1 = w_rf[ReadRegister1];
    ReadData2 = w_rf[ReadRegister2];
    if (w_byp1) begin
      ReadData1 = WriteData;
    end
    if (w_byp2) begin
      ReadData2 = WriteData;
    end
  end
`else
  // Combinational read ports. A same-cycle write becomes visible after the edge.
  always_comb begin
    ReadData1 = w_rf[ReadRegister1];
    ReadData2 = w_rf[ReadRegister2];
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_32x64.sv
//-----------------------------------------------------------------------------
// Module   : tb_regfile_32x64
// Brief    : Scoreboard bench for regfile_32x64. The stimulus side records
//            the expected read data from an array model of the architectural
//            registers. A monitor samples both read ports and compares them.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_regfile_32x64;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  regfile_32x64 #(.DATA_WIDTH(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] e1;
    logic [63:0] e2;
    logic [4:0]  a1;
    logic [4:0]  a2;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  event        ev_sample;
  int          total = 0;
  int          bad   = 0;

  // Architectural state: X0-X30 hold values, and X31 always reads zero.
  logic [63:0] model [0:31];

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
  endfunction

  // Value that a read port must show for address a under the current inputs
  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    logic [63:0] v;
    v = (a == 5'd31) ? 64'd0 : model[a];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (RegWrite && !reset && WriteRegister != 5'd31 && WriteRegister == a)
      v = WriteData;
`endif
    return v;
  endfunction

  // Issue a read request and queue the expected result for the monitor
  task automatic check(input logic [4:0] a1, input logic [4:0] a2, input string nm);
    exp_t e;
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    #1;
    e.e1 = exp_rd(a1);
    e.e2 = exp_rd(a2);
    e.a1 = a1;
    e.a2 = a2;
    exp_q.push_back(e);
    name_q.push_back(nm);
    -> ev_sample;
    #1;
  endtask

  // Advance one clock edge and apply the architectural effect of that edge
  task automatic tick();
    @(posedge clk);
    if (reset) model_clear();
    else if (RegWrite && WriteRegister != 5'd31) model[WriteRegister] = WriteData;
    @(negedge clk);
    RegWrite = 1'b0;
  endtask

  task automatic wr(input logic we, input logic [4:0] a, input logic [63:0] d);
    RegWrite      = we;
    WriteRegister = a;
    WriteData     = d;
    tick();
  endtask

  // Monitor: compare each sampled read against the oldest queued expectation
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(ev_sample);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty got=%h/%h exp=none", ReadData1, ReadData2);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (ReadData1 !== e.e1 || ReadData2 !== e.e2) begin
          bad++;
          $display("FAIL %s rr1=%0d rr2=%0d got=%h/%h exp=%h/%h",
                   nm, e.a1, e.a2, ReadData1, ReadData2, e.e1, e.e2);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    reset         = 1'b1;
    RegWrite      = 1'b0;
    WriteRegister = 5'd0;
    WriteData     = 64'd0;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;

    // Reset state
    @(negedge clk);
    check(5'd0, 5'd30, "reset_state");
    check(5'd5, 5'd31, "reset_state");
    reset = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a cycle
    wr(1'b1, 5'd5, 64'h0000_0000_DEAD_BEEF);
    check(5'd5, 5'd5, "load_x5");
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_clear();
    check(5'd5, 5'd5, "async_reset");
    @(negedge clk);
    reset = 1'b0;

    // Write every register, then read the pairs (i, 30-i)
    for (int i = 0; i < 31; i++) wr(1'b1, 5'(i), 64'h1111_1111_0000_0000 + 64'(i));
    for (int i = 0; i < 31; i++) check(5'(i), 5'(30 - i), "write_read_all");

    // Zero register ignores writes
    wr(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    check(5'd31, 5'd31, "xzr_read");
    check(5'd30, 5'd0, "xzr_no_disturb");

    // RegWrite low leaves the target unchanged
    wr(1'b1, 5'd7, 64'h55);
    wr(1'b0, 5'd7, 64'h1234);
    check(5'd7, 5'd7, "regwrite_low");

    // Same-cycle read of the write target, then the read after the edge
    wr(1'b1, 5'd3, 64'hAA);
    RegWrite      = 1'b1;
    WriteRegister = 5'd3;
    WriteData     = 64'hBB;
    check(5'd3, 5'd4, "same_cycle_read");
    tick();
    check(5'd3, 5'd3, "after_edge_read");

    // A write on a clock edge while reset is high is lost
    wr(1'b1, 5'd9, 64'h99);
    RegWrite      = 1'b1;
    WriteRegister = 5'd9;
    WriteData     = 64'h77;
    reset         = 1'b1;
    model_clear();
    tick();
    reset = 1'b0;
    check(5'd9, 5'd9, "reset_coincident_write");

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      RegWrite      = 1'($urandom_range(0, 1));
      WriteRegister = 5'($urandom);
      WriteData     = {$urandom, $urandom};
      if (n % 3 == 0) check(WriteRegister, 5'($urandom), "random_hit");
      else            check(5'($urandom), 5'($urandom), "random");
      tick();
    end
    for (int i = 0; i < 32; i++) check(5'(i), 5'(31 - i), "final_sweep");

    #2;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
